// File: rtl/pipelined_adder.sv
// Purpose : pipelined ripple-carry adder, sum = (a + b + cin) mod 2^WIDTH, carry split into CHUNK-bit stages.
// Latency : NSTAGES = WIDTH/CHUNK cycles from accept to out_valid; one result per clock sustained.
// Backpressure: global stall; when out_valid && !out_ready every stage holds and in_ready drops.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     operand handshake for a, b, cin (and sub when enabled)
//   out_valid/out_ready   result handshake for sum, cout
//   a, b [WIDTH-1:0]      operands; cin carry-in
//   sum [WIDTH-1:0]       modular sum; cout carry out of bit WIDTH-1
//
// Optional feature macro: ADDER_SUB_EN
//   Adds input 'sub'. With sub=1 the block computes a + ~b + 1 (cin ignored);
//   cout=1 then means no borrow (a >= b unsigned).
//
// WIDTH must be a multiple of CHUNK, and WIDTH/CHUNK must be in 1..16.

module pipelined_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NSTAGES = WIDTH / CHUNK;

  // Per-stage pipeline registers. a_q/b_q carry the full operands so later
  // stages can pick up their still-unprocessed upper chunks; s_q carries the
  // sum bits completed so far; c_q is the carry into the next chunk.
  logic             v_q [NSTAGES];
  logic [WIDTH-1:0] a_q [NSTAGES];
  logic [WIDTH-1:0] b_q [NSTAGES];
  logic [WIDTH-1:0] s_q [NSTAGES];
  logic             c_q [NSTAGES];

  logic             v_d [NSTAGES];
  logic [WIDTH-1:0] a_d [NSTAGES];
  logic [WIDTH-1:0] b_d [NSTAGES];
  logic [WIDTH-1:0] s_d [NSTAGES];
  logic             c_d [NSTAGES];

  logic             en;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  // Subtraction is folded in before stage 0: invert b and force the carry-in,
  // so the rest of the pipeline is a plain adder and needs no mode bit.
`ifdef ADDER_SUB_EN
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub ? 1'b1 : cin;
`else
  assign b_eff   = b;
  assign cin_eff = cin;
`endif

  // Single global enable: the whole pipe advances unless the output is
  // holding a result the consumer has not taken. Empty stages shift too.
  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;

  // Next-state for every stage. The cur_* variables walk along the pipe:
  // they start at the ports (input of stage 0) and are then switched to the
  // registers of stage k, which feed stage k+1.
  always_comb begin
    logic [WIDTH-1:0] cur_a;
    logic [WIDTH-1:0] cur_b;
    logic [WIDTH-1:0] cur_s;
    logic             cur_c;
    logic             cur_v;
    logic [CHUNK:0]   part;

    cur_a = a;
    cur_b = b_eff;
    cur_s = '0;
    cur_c = cin_eff;
    cur_v = in_valid;
    part  = '0;

    for (int k = 0; k < NSTAGES; k++) begin
      part = {1'b0, cur_a[k*CHUNK +: CHUNK]}
           + {1'b0, cur_b[k*CHUNK +: CHUNK]}
           + {{CHUNK{1'b0}}, cur_c};

      v_d[k]                   = cur_v;
      a_d[k]                   = cur_a;
      b_d[k]                   = cur_b;
      s_d[k]                   = cur_s;
      s_d[k][k*CHUNK +: CHUNK] = part[CHUNK-1:0];
      c_d[k]                   = part[CHUNK];

      cur_a = a_q[k];
      cur_b = b_q[k];
      cur_s = s_q[k];
      cur_c = c_q[k];
      cur_v = v_q[k];
    end
  end

  // Datapath is reset as well so sum/cout read 0 while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NSTAGES; k++) begin
        v_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
      end
    end else if (en) begin
      for (int k = 0; k < NSTAGES; k++) begin
        v_q[k] <= v_d[k];
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
        c_q[k] <= c_d[k];
      end
    end
  end

  assign out_valid = v_q[NSTAGES-1];
  assign sum       = s_q[NSTAGES-1];
  assign cout      = c_q[NSTAGES-1];

endmodule

// File: tb/tb_pipelined_adder.sv
// Purpose : directed + random check of pipelined_adder at WIDTH=8, CHUNK=4 (two stages).
// Latency : expects out_valid two edges after accept, one extra edge per stall cycle.
// Backpressure: drives out_ready low to check freeze, in_ready drop and in-order drain.

module tb_pipelined_adder;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
`ifdef ADDER_SUB_EN
  logic       sub;
`endif
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum;
  logic       cout;

  int nvec = 0;
  int nerr = 0;

  pipelined_adder #(.WIDTH(8), .CHUNK(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef ADDER_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then return at the following falling edge
  // where outputs are sampled and new inputs are driven.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [7:0] av, input logic [7:0] bv, input logic cv);
    in_valid = v;
    a        = av;
    b        = bv;
    cin      = cv;
  endtask

  initial begin
    logic [8:0] q[$];
    logic [8:0] exp;
    int  sent;
    int  got;
    int  cyc;
    logic acc;
    logic dlv;

    rst_n     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 8'h00, 8'h00, 1'b0);
`ifdef ADDER_SUB_EN
    sub = 1'b0;
`endif

    // ---------------- reset state ----------------
    @(negedge clk);
    tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", in_ready, 1);

    // ---------------- carry across chunk boundary ----------------
    drive(1'b1, 8'hFF, 8'h01, 1'b0);
    tick();
    in_valid = 1'b0;
    check("t1_lat_early", out_valid, 0);
    tick();
    check("t1_valid", out_valid, 1);
    check("t1_sum", sum, 8'h00);
    check("t1_cout", cout, 1);
    tick();
    check("t1_drained", out_valid, 0);

    // ---------------- back-to-back streaming ----------------
    drive(1'b1, 8'd12, 8'd34, 1'b0);
    tick();
    check("t2_in_ready0", in_ready, 1);
    drive(1'b1, 8'h80, 8'h80, 1'b1);
    tick();
    check("t2_v0", out_valid, 1);
    check("t2_r0", {cout, sum}, {1'b0, 8'd46});
    check("t2_in_ready1", in_ready, 1);
    drive(1'b1, 8'h0F, 8'h01, 1'b0);
    tick();
    check("t2_v1", out_valid, 1);
    check("t2_r1", {cout, sum}, {1'b1, 8'h01});
    in_valid = 1'b0;
    tick();
    check("t2_v2", out_valid, 1);
    check("t2_r2", {cout, sum}, {1'b0, 8'h10});
    tick();
    check("t2_drained", out_valid, 0);

    // ---------------- backpressure ----------------
    out_ready = 1'b0;
    drive(1'b1, 8'h03, 8'h04, 1'b0);
    tick();
    drive(1'b1, 8'h10, 8'h20, 1'b0);
    tick();
    in_valid = 1'b0;
    check("t3_v", out_valid, 1);
    check("t3_in_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_hold_v", out_valid, 1);
      check("t3_hold_res", {cout, sum}, {1'b0, 8'h07});
      check("t3_hold_rdy", in_ready, 0);
    end
    out_ready = 1'b1;
    #1;
    check("t3_release_rdy", in_ready, 1);
    tick();
    check("t3_second_v", out_valid, 1);
    check("t3_second_res", {cout, sum}, {1'b0, 8'h30});
    tick();
    check("t3_no_dup", out_valid, 0);

    // ---------------- asynchronous reset mid-flight ----------------
    out_ready = 1'b0;
    drive(1'b1, 8'hAA, 8'h55, 1'b1);
    tick();
    drive(1'b1, 8'h11, 8'h22, 1'b0);
    tick();
    in_valid = 1'b0;
    check("t4_pre_v", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("t4_async_v", out_valid, 0);
    check("t4_async_sum", sum, 0);
    check("t4_async_cout", cout, 0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_no_stale", out_valid, 0);
    end
    check("t4_in_ready", in_ready, 1);

`ifdef ADDER_SUB_EN
    // ---------------- subtract mode ----------------
    sub = 1'b1;
    drive(1'b1, 8'h05, 8'h07, 1'b0);
    tick();
    drive(1'b1, 8'h07, 8'h05, 1'b1);
    tick();
    in_valid = 1'b0;
    sub      = 1'b0;
    check("t5_v0", out_valid, 1);
    check("t5_borrow", {cout, sum}, {1'b0, 8'hFE});
    tick();
    check("t5_v1", out_valid, 1);
    check("t5_noborrow", {cout, sum}, {1'b1, 8'h02});
    tick();
`endif

    // ---------------- random stream with random backpressure ----------------
    sent = 0;
    got  = 0;
    cyc  = 0;
    in_valid = 1'b0;
    while ((sent < 1000 || q.size() != 0) && cyc < 20000) begin
      if (!in_valid && sent < 1000 && $urandom_range(0, 3) != 0) begin
        drive(1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
      end
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      acc = in_valid && in_ready;
      dlv = out_valid && out_ready;
      if (dlv) begin
        if (q.size() == 0) begin
          check("rnd_spurious", 1, 0);
        end else begin
          exp = q.pop_front();
          check("rnd_result", {cout, sum}, exp);
          got++;
        end
      end
      if (acc) begin
        q.push_back({1'b0, a} + {1'b0, b} + {8'd0, cin});
        sent++;
      end
      tick();
      if (acc) in_valid = 1'b0;
      cyc++;
    end
    check("rnd_count", got, 1000);
    check("rnd_leftover", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
